alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the 8-bit combinational ALU in the single-cycle CPU datapath.
- Adds subtraction, iterative shifts and an optional iterative multiplier to forward/add/and/or, all at configurable width.
- Operands are captured on a start handshake, and flags are registered with the result.
- Sits between the register file read ports and the writeback mux; the control unit stalls on BUSY and writes back on DONE.

---
 rtl/alu_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake.
// Forward, add, and, or, sub, iterative shifts (SLL/ASR, one bit per step) and,
// when the ALU_MUL_EN macro is defined, an iterative unsigned shift-add multiplier.
// Without ALU_MUL_EN, opcode 111 finishes in one step and flags ERR.
// Result and flags are registered together and held between DONE pulses.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       select_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_ASR = 3'b110;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t                state_q;
  logic [2:0]            op_q;
  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic [CW-1:0]         cnt_q;
  logic                  sh_cy_q, sh_cy_d;
  logic                  shamt_nz;
  logic signed [WIDTH-1:0] a_s;
  logic [WIDTH:0]        sum_add;
  logic [WIDTH-1:0]      res_d, hi_res_d;
  logic                  cy_d, err_d;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]      hi_q, hi_d;
  logic [WIDTH:0]        mul_sum;
`endif

  // Number of EXEC steps for an opcode; shifts take max(amount,1) steps.
  function automatic logic [CW-1:0] step_count(input logic [2:0] op,
                                               input logic [SHW-1:0] amt);
    logic [CW-1:0] n;
    n = CW'(1);
    if ((op == OP_SLL || op == OP_ASR) && amt != '0) n = CW'(amt);
`ifdef ALU_MUL_EN
    if (op == 3'b111) n = CW'(WIDTH);
`endif
    return n;
  endfunction

  assign a_s = a_q;

  // One datapath step plus the value to commit if this is the last step.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sh_cy_d  = sh_cy_q;
    res_d    = '0;
    hi_res_d = '0;
    cy_d     = 1'b0;
    err_d    = 1'b0;
    shamt_nz = (b_q[SHW-1:0] != '0);
    sum_add  = {1'b0, a_q} + {1'b0, b_q};
`ifdef ALU_MUL_EN
    hi_d     = hi_q;
    mul_sum  = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : '0);
`endif
    case (op_q)
      OP_FWD: res_d = b_q;
      OP_ADD: begin
        res_d = sum_add[WIDTH-1:0];
        cy_d  = sum_add[WIDTH];
      end
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_SUB: begin
        res_d = a_q - b_q;
        cy_d  = (a_q >= b_q);
      end
      OP_SLL: begin
        if (shamt_nz) begin
          a_d     = {a_q[WIDTH-2:0], 1'b0};
          sh_cy_d = a_q[WIDTH-1];
        end
        res_d = a_d;
        cy_d  = sh_cy_d;
      end
      OP_ASR: begin
        if (shamt_nz) begin
          a_d     = a_s >>> 1;
          sh_cy_d = a_q[0];
        end
        res_d = a_d;
        cy_d  = sh_cy_d;
      end
      default: begin
`ifdef ALU_MUL_EN
        // Product accumulates in hi_q while the multiplier shifts out of b_q.
        hi_d     = mul_sum[WIDTH:1];
        b_d      = {mul_sum[0], b_q[WIDTH-1:1]};
        res_d    = b_d;
        hi_res_d = hi_d;
        cy_d     = |hi_d;
`else
        err_d    = 1'b1;
`endif
      end
    endcase
  end

  // Control FSM with operand capture, stepping and registered result/flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      sh_cy_q     <= 1'b0;
`ifdef ALU_MUL_EN
      hi_q        <= '0;
`endif
      result_o    <= '0;
      result_hi_o <= '0;
      zero_o      <= 1'b0;
      carry_o     <= 1'b0;
      err_o       <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q    <= select_i;
            a_q     <= data1_i;
            b_q     <= data2_i;
            sh_cy_q <= 1'b0;
`ifdef ALU_MUL_EN
            hi_q    <= '0;
`endif
            cnt_q   <= step_count(select_i, data2_i[SHW-1:0]);
            busy_o  <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          a_q     <= a_d;
          b_q     <= b_d;
          sh_cy_q <= sh_cy_d;
`ifdef ALU_MUL_EN
          hi_q    <= hi_d;
`endif
          cnt_q   <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_o    <= res_d;
            result_hi_o <= hi_res_d;
            zero_o      <= (res_d == '0);
            carry_o     <= cy_d;
            err_o       <= err_d;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized test of alu_seq against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int W   = 8;
  localparam int SHW = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   sel;
  logic [W-1:0] d1, d2;
  logic [W-1:0] result, result_hi;
  logic         zero, carry, err, busy, done;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .select_i(sel),
    .data1_i(d1), .data2_i(d2),
    .result_o(result), .result_hi_o(result_hi), .zero_o(zero),
    .carry_o(carry), .err_o(err), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outcome from the opcode definitions using plain arithmetic.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [W-1:0] rh,
                                output logic c, output logic e, output int n);
    int s;
    logic [2*W-1:0] p;
    logic signed [W-1:0] sa;
    s = int'(b) % W;
    r = '0; rh = '0; c = 1'b0; e = 1'b0; n = 1;
    p = '0; sa = a;
    case (op)
      3'd0: r = b;
      3'd1: begin p = a + b; r = p[W-1:0]; c = p[W]; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin r = a - b; c = (a >= b); end
      3'd5: begin
        p = {{W{1'b0}}, a} << s;
        r = p[W-1:0];
        c = (s > 0) ? p[W] : 1'b0;
        n = (s > 0) ? s : 1;
      end
      3'd6: begin
        r = sa >>> s;
        c = (s > 0) ? a[s-1] : 1'b0;
        n = (s > 0) ? s : 1;
      end
      default: begin
`ifdef ALU_MUL_EN
        p  = a * b;
        r  = p[W-1:0];
        rh = p[2*W-1:W];
        c  = |rh;
        n  = W;
`else
        e  = 1'b1;
`endif
      end
    endcase
  endfunction

  // Issue one operation (called #1 after a rising edge) and check it through DONE.
  // inj >= 0 pulses START with an ADD after that many EXEC edges.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj);
    logic [W-1:0] er, eh;
    logic ec, ee;
    int en, n;
    model(op, a, b, er, eh, ec, ee, en);
    sel = op; d1 = a; d2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    check("done_after_accept", done, 1'b0);
    d1 = W'($urandom); d2 = W'($urandom); sel = 3'($urandom);
    n = 0;
    while (!done && n < 200) begin
      if (n == inj) begin start = 1'b1; sel = 3'b001; end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (n < en) check("busy_exec", busy, 1'b1);
    end
    check("latency", n, en);
    check("result", result, er);
    check("result_hi", result_hi, eh);
    check("zero", zero, (er == '0));
    check("carry", carry, ec);
    check("err", err, ee);
    check("busy_at_done", busy, 1'b0);
  endtask

  initial begin
    logic [2:0] lop;
    logic [W-1:0] la, lb;
    logic seen;
    rst = 1'b1; start = 1'b0; sel = '0; d1 = '0; d2 = '0;
    #12;
    check("rst_result", result, 0);
    check("rst_result_hi", result_hi, 0);
    check("rst_flags", {zero, carry, err, busy, done}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases; consecutive calls also exercise issue in the DONE cycle.
    run_op(3'd1, 8'hF0, 8'h20, -1);
    run_op(3'd4, 8'h05, 8'h05, -1);
    run_op(3'd4, 8'h03, 8'h05, -1);
    run_op(3'd6, 8'h83, 8'h02, -1);
    run_op(3'd5, 8'h81, 8'h00, -1);
    run_op(3'd7, 8'hFF, 8'hFF, -1);
    run_op(3'd3, 8'h0C, 8'h30, -1);
    run_op(3'd1, 8'h11, 8'h22, -1);
    // START with ADD during execution must be ignored.
    run_op(3'd7, 8'hFF, 8'hFF, 3);
    run_op(3'd6, 8'h40, 8'h07, 3);

    // Outputs hold while idle.
    repeat (3) @(posedge clk);
    #1;
    check("hold_result", result, 8'h00);
    check("hold_done", done, 1'b0);

    // Mid-operation asynchronous reset.
    run_op(3'd1, 8'hF0, 8'h20, -1);
`ifdef ALU_MUL_EN
    lop = 3'd7; la = 8'hFF; lb = 8'hFF;
`else
    lop = 3'd6; la = 8'h83; lb = 8'h07;
`endif
    sel = lop; d1 = la; d2 = lb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_result", result, 0);
    check("arst_result_hi", result_hi, 0);
    check("arst_flags", {zero, carry, err, busy, done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("no_done_after_abort", seen, 1'b0);
    check("idle_after_abort", busy, 1'b0);

    // Randomized back-to-back operations.
    for (int i = 0; i < 150; i++) begin
      run_op(3'($urandom), W'($urandom), W'($urandom), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
